// File: rtl/sramlike_sram_responder.sv
// Sram-like bus responder driving a 1-cycle-latency single-port SRAM; one transaction in flight.
// Optional macro SRAMLIKE_RAND_DELAY_EN gates addr_ok with an LFSR to stall the master randomly.
module sramlike_sram_responder #(
    parameter int RAM_AW = 16,
    parameter int DELAY  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = (DELAY > 0) ? 4'(DELAY - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic        cap_q;
    logic [31:0] rdata_q;
    logic        ready;
    logic        handshake;
    logic [31:0] resp_data;
    logic        unused_addr;

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            2'd0:    be = 4'b0001 << lo;
            2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

`ifdef SRAMLIKE_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign ready = lfsr[0];
`else
    assign ready = 1'b1;
`endif

    // Qualifying with rst keeps the handshake outputs low for the whole reset window.
    assign addr_ok   = rst & (state == IDLE) & ready;
    assign data_ok   = rst & (state == RESP);
    assign handshake = addr_ok & req;

    assign ram_en    = handshake;
    assign ram_wen   = (handshake && wr) ? byte_en(size, addr[1:0]) : 4'b0000;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    assign resp_data = (DELAY == 0) ? ram_rdata : rdata_q;
    assign rdata     = (data_ok && !wr_q) ? resp_data : 32'd0;

    assign unused_addr = ^{addr[31:RAM_AW+2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            cap_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            cap_q <= handshake;
            if (handshake) begin
                wr_q <= wr;
            end
            // SRAM data is only valid the cycle after the access; hold it from then on.
            if (cap_q) begin
                rdata_q <= wr_q ? 32'd0 : ram_rdata;
            end
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cnt   <= 4'd0;
                        state <= (DELAY > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sramlike_sram_responder.sv
// Directed bench: DELAY=0 responder backed by a small SRAM model, DELAY=3 responder with driven ram_rdata.
module tb_sramlike_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT0: DELAY = 0
    logic        rst0, req0, wr0;
    logic [1:0]  size0;
    logic [31:0] addr0, wdata0, rdata0, ram_wdata0, ram_rdata0;
    logic        addr_ok0, data_ok0, ram_en0;
    logic [3:0]  ram_wen0;
    logic [7:0]  ram_addr0;

    // DUT1: DELAY = 3
    logic        rst1, req1, wr1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1, rdata1, ram_wdata1, ram_rdata1;
    logic        addr_ok1, data_ok1, ram_en1;
    logic [3:0]  ram_wen1;
    logic [7:0]  ram_addr1;

    sramlike_sram_responder #(.RAM_AW(8), .DELAY(0)) dut0 (
        .clk(clk), .rst(rst0), .req(req0), .wr(wr0), .size(size0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .addr_ok(addr_ok0), .data_ok(data_ok0),
        .ram_en(ram_en0), .ram_wen(ram_wen0), .ram_addr(ram_addr0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    sramlike_sram_responder #(.RAM_AW(8), .DELAY(3)) dut1 (
        .clk(clk), .rst(rst1), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
        .wdata(wdata1), .rdata(rdata1), .addr_ok(addr_ok1), .data_ok(data_ok1),
        .ram_en(ram_en1), .ram_wen(ram_wen1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    // Synchronous SRAM model for DUT0, read-first, 1-cycle read latency
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_en0) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen0[b]) mem[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
            end
            ram_rdata0 <= mem[ram_addr0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive0(input logic r, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        req0 = r; wr0 = w; size0 = s; addr0 = a; wdata0 = d;
    endtask

    // One DELAY=0 write: wen at T, data_ok with rdata 0 at T+1
    task automatic write0(input string tag, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_wen);
        tick();
        drive0(1'b1, 1'b1, s, a, d);
        mid();
        check({tag, "_wen"}, {28'd0, ram_wen0}, {28'd0, exp_wen});
        check({tag, "_ram_en"}, {31'd0, ram_en0}, 32'd1);
        tick();
        drive0(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        mid();
        check({tag, "_data_ok"}, {31'd0, data_ok0}, 32'd1);
        check({tag, "_rdata0"}, rdata0, 32'd0);
    endtask

    task automatic read0(input string tag, input logic [31:0] a, input logic [31:0] exp);
        tick();
        drive0(1'b1, 1'b0, 2'd2, a, 32'd0);
        mid();
        check({tag, "_ram_en"}, {31'd0, ram_en0}, 32'd1);
        tick();
        drive0(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        mid();
        check({tag, "_data_ok"}, {31'd0, data_ok0}, 32'd1);
        check({tag, "_rdata"}, rdata0, exp);
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        drive0(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        req1 = 1'b0; wr1 = 1'b0; size1 = 2'd2; addr1 = 32'd0; wdata1 = 32'd0;
        ram_rdata1 = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h5555AAAA;

        // Reset state, with req asserted to show the outputs are forced
        req0 = 1'b1;
        repeat (2) mid();
        check("rst_addr_ok", {31'd0, addr_ok0}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en0}, 32'd0);
        check("rst_data_ok", {31'd0, data_ok0}, 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst1_addr_ok", {31'd0, addr_ok1}, 32'd0);
        req0 = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1;

        // 1: word read at 0x10
        tick();
        drive0(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
        mid();
        check("t1_addr_ok", {31'd0, addr_ok0}, 32'd1);
        check("t1_ram_en", {31'd0, ram_en0}, 32'd1);
        check("t1_ram_addr", {24'd0, ram_addr0}, 32'd4);
        check("t1_ram_wen", {28'd0, ram_wen0}, 32'd0);
        check("t1_data_ok_T", {31'd0, data_ok0}, 32'd0);
        tick();
        drive0(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        mid();
        check("t1_data_ok", {31'd0, data_ok0}, 32'd1);
        check("t1_rdata", rdata0, 32'hDEADBEEF);
        check("t1_addr_ok_T1", {31'd0, addr_ok0}, 32'd0);

        // 2: byte write to lane 3, then read back
        write0("t2_byte", 2'd0, 32'h13, 32'hAB000000, 4'b1000);
        read0("t2_rd", 32'h10, 32'hABADBEEF);
        write0("t2_byte0", 2'd0, 32'h30, 32'h000000C3, 4'b0001);

        // 3: halfword and size-3 writes
        write0("t3_half", 2'd1, 32'h22, 32'h12340000, 4'b1100);
        write0("t3_half_lo", 2'd1, 32'h25, 32'h00005678, 4'b0011);
        write0("t3_sz3", 2'd3, 32'h20, 32'hCAFEF00D, 4'b1111);
        read0("t3_rd", 32'h20, 32'hCAFEF00D);
        read0("t3_rd_half", 32'h24, 32'h00005678);

        // 5: req held for two back-to-back reads
        tick();
        drive0(1'b1, 1'b0, 2'd2, 32'h10, 32'd0);
        mid();
        check("t5_hs0", {31'd0, ram_en0}, 32'd1);
        check("t5_coinc0", {31'd0, addr_ok0 & data_ok0}, 32'd0);
        tick();
        mid();
        check("t5_dok0", {31'd0, data_ok0}, 32'd1);
        check("t5_rdata0", rdata0, 32'hABADBEEF);
        check("t5_no_hs", {31'd0, ram_en0}, 32'd0);
        check("t5_coinc1", {31'd0, addr_ok0 & data_ok0}, 32'd0);
        tick();
        addr0 = 32'h14;
        mid();
        check("t5_hs1", {31'd0, ram_en0}, 32'd1);
        check("t5_hs1_addr", {24'd0, ram_addr0}, 32'd5);
        check("t5_coinc2", {31'd0, addr_ok0 & data_ok0}, 32'd0);
        tick();
        drive0(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        mid();
        check("t5_dok1", {31'd0, data_ok0}, 32'd1);
        check("t5_rdata1", rdata0, 32'h5555AAAA);
        check("t5_coinc3", {31'd0, addr_ok0 & data_ok0}, 32'd0);

        // 4: DELAY=3, ram_rdata changes after capture
        tick();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h30;
        mid();
        check("t4_ram_en", {31'd0, ram_en1}, 32'd1);
        check("t4_ram_addr", {24'd0, ram_addr1}, 32'h0C);
        tick();
        req1 = 1'b0; ram_rdata1 = 32'h12345678;
        mid();
        check("t4_dok_T1", {31'd0, data_ok1}, 32'd0);
        check("t4_aok_T1", {31'd0, addr_ok1}, 32'd0);
        tick();
        ram_rdata1 = 32'hFFFF0000;
        mid();
        check("t4_dok_T2", {31'd0, data_ok1}, 32'd0);
        tick();
        mid();
        check("t4_dok_T3", {31'd0, data_ok1}, 32'd0);
        tick();
        mid();
        check("t4_dok_T4", {31'd0, data_ok1}, 32'd1);
        check("t4_rdata", rdata1, 32'h12345678);
        check("t4_aok_T4", {31'd0, addr_ok1}, 32'd0);
        tick();
        mid();
        check("t4_dok_T5", {31'd0, data_ok1}, 32'd0);
        check("t4_aok_T5", {31'd0, addr_ok1}, 32'd1);

        // 6: reset during WAIT drops the transaction
        tick();
        req1 = 1'b1; addr1 = 32'h40; ram_rdata1 = 32'd0;
        mid();
        check("t6_hs", {31'd0, ram_en1}, 32'd1);
        tick();
        req1 = 1'b0; ram_rdata1 = 32'h77777777;
        tick();
        rst1 = 1'b0; req1 = 1'b1; wr1 = 1'b1;
        #1;
        check("t6_rst_dok", {31'd0, data_ok1}, 32'd0);
        check("t6_rst_aok", {31'd0, addr_ok1}, 32'd0);
        check("t6_rst_en", {31'd0, ram_en1}, 32'd0);
        check("t6_rst_wen", {28'd0, ram_wen1}, 32'd0);
        check("t6_rst_rdata", rdata1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            mid();
            check("t6_rst_hold_dok", {31'd0, data_ok1}, 32'd0);
        end
        rst1 = 1'b1; wr1 = 1'b0; addr1 = 32'h44;
        #1;
        check("t6_post_aok", {31'd0, addr_ok1}, 32'd1);
        check("t6_post_en", {31'd0, ram_en1}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) begin
                req1 = 1'b0; ram_rdata1 = 32'h0BADF00D;
            end else begin
                ram_rdata1 = 32'd0;
            end
            mid();
            check("t6_post_dok", {31'd0, data_ok1}, (i == 4) ? 32'd1 : 32'd0);
        end
        check("t6_post_rdata", rdata1, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
